td4_top: RTL and testbench
==========================

Name: td4_top

Overview:
- Complete 4-bit TD4-class CPU: two general registers A and B, 4-bit program counter, carry flag, 4-bit output latch, and a 16 x 8-bit instruction ROM loaded from a parameter.
- Executes one instruction per rising clock edge.
- Reads a 4-bit switch input port and drives a 4-bit LED output port.
- Top-level block of the FPGA design.

Parameters:
- PROGRAM, default 128'h0000_0000_0000_0000_0000_0000_F151_9070. ROM image; byte at address n is PROGRAM[8n+7:8n].
- Default program:
  - 0: MOV B,0
  - 1: OUT B
  - 2: ADD B,1
  - 3: JMP 1
  - 4-F: 0x00
- The default program runs an LED counter.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  4  input port, read by IN instructions.
- LED  output  4  output port; the current value of the OUT register.

Behaviour:
- State: A[3:0], B[3:0], OUT[3:0], PC[3:0], C (1 bit). LED = OUT, combinational, no extra delay.
- reset low clears A, B, OUT, PC and C to 0 immediately, without waiting for a clock edge. Values hold while reset stays low.
- reset may start at X. After a low pulse the state is fully defined.
- Single-cycle execution. On each rising edge with reset high:
  - fetch ROM[PC];
  - split it as op = bits[7:4], im = bits[3:0];
  - execute the instruction;
  - PC <= next PC.
- The first edge after reset is released executes ROM[0].
- Datapath: sum5 = src + im (5-bit); result = sum5[3:0]; C <= sum5[4] on every instruction.
- src is the operand selected below. MOV, IN, OUT and jump instructions select a source that makes carry 0, so C is 1 only after an ADD that overflowed.
- Opcodes:
  - 0000 ADD A,im: A <= A+im; C <= carry.
  - 0001 MOV A,B: A <= B (im ignored).
  - 0010 IN A: A <= sw.
  - 0011 MOV A,im: A <= im.
  - 0100 MOV B,A: B <= A.
  - 0101 ADD B,im: B <= B+im; C <= carry.
  - 0110 IN B: B <= sw.
  - 0111 MOV B,im: B <= im.
  - 1001 OUT B: OUT <= B.
  - 1011 OUT im: OUT <= im.
  - 1110 JNC im: if C==0 (flag from the previous instruction), PC <= im; else PC <= PC+1.
  - 1111 JMP im: PC <= im.
- The four non-ADD opcodes above that write A or B add im=0, so MOV, IN and OUT behave as specified with im bits treated as 0 where unused.
- Every instruction that is not a jump clears C unless it is an ADD.
- Every non-listed opcode (1000, 1010, 1100, 1101) is a NOP: PC+1, registers unchanged, C <= 0.
- PC increments modulo 16: F wraps to 0.
- ADD wraps modulo 16 and sets C on overflow. Example: F+1 gives 0 with C=1.
- sw is sampled at the executing rising edge. There is no synchronizer; the bench keeps sw stable around edges.
- An asynchronous reset asserted mid-program aborts the program. Execution restarts at address 0 on the first edge after release.

Test Plan:
- Reset: reset low for 155 ns at any clock phase -> A=B=OUT=PC=C=0 and LED=0, asserted before the next edge.
- Default program, sw=0: after release, LED=0 after edge 2, 1 after edge 5, k after edge 2+3k. At k=16, LED wraps to 0 (ADD B,1 from F sets C=1). Counting continues.
- IN/MOV/OUT, PROGRAM bytes 0:0x20 1:0x40 2:0x90 3:0xF3, sw=0101 -> LED=5 after edge 3. LED holds 5 thereafter.
- JNC not taken on carry, bytes 0:0x3E 1:0x01 2:0x01 3:0xE0 4:0xB9 5:0xF5 -> A=F and C=0 after edge 2; A=0 and C=1 after edge 3; edge 4 falls through; LED=9 after edge 5 and stays.
- JNC taken, bytes 0:0x31 1:0xE3 2:0xBF 3:0xB6 4:0xF4 -> LED becomes 6 and never shows F.
- Mid-run reset: run the default program until LED=7, pulse reset low -> LED=0 at once. The counter sequence restarts from 0 after release.

Source files
------------

// File: rtl/td4_top.sv
// td4_top -- a complete 4-bit TD4-class CPU. It executes one instruction per
// rising clock edge from a 16 x 8-bit ROM image that is supplied as a parameter.
//
// State: general registers A and B, a 4-bit PC, a carry flag C and a 4-bit
// output latch. Every instruction goes through a single 4-bit adder,
// sum5 = src + addend. Instructions other than ADD pick operands that
// cannot overflow, so they always leave C at 0.
//
// Parameters:
//   PROGRAM  ROM image; the byte at address n is PROGRAM[8n+7:8n].
//            The default program is an LED counter.
//
// Ports:
//   clock  in   system clock; all state changes on the rising edge
//   reset  in   asynchronous, active-low; clears A, B, OUT, PC and C
//   sw     in   4-bit input port, sampled by IN A / IN B
//   LED    out  4-bit output port, the OUT latch with no extra delay
module td4_top #(
    parameter logic [127:0] PROGRAM = 128'h0000_0000_0000_0000_0000_0000_F151_9070
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sw,
    output logic [3:0] LED
);

    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out_q;
    logic [3:0] pc;
    logic       c;

    logic [7:0] ins;
    logic [3:0] op;
    logic [3:0] im;

    logic [3:0] src;
    logic [3:0] addend;
    logic [4:0] sum5;
    logic [3:0] result;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic [3:0] pc_next;

    function automatic logic [4:0] add5(input logic [3:0] x, input logic [3:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    assign ins    = PROGRAM[{pc, 3'b000} +: 8];
    assign op     = ins[7:4];
    assign im     = ins[3:0];
    assign sum5   = add5(src, addend);
    assign result = sum5[3:0];
    assign LED    = out_q;

    // Decode. When an operand is unused it is left at 0. The defaults turn
    // every unlisted opcode into a NOP that clears C.
    always_comb begin
        src     = 4'd0;
        addend  = 4'd0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_out  = 1'b0;
        pc_next = pc + 4'd1;
        case (op)
            4'b0000: begin src = a;  addend = im; ld_a = 1'b1; end  // ADD A,im
            4'b0001: begin src = b;  ld_a = 1'b1; end               // MOV A,B
            4'b0010: begin src = sw; ld_a = 1'b1; end               // IN A
            4'b0011: begin addend = im; ld_a = 1'b1; end            // MOV A,im
            4'b0100: begin src = a;  ld_b = 1'b1; end               // MOV B,A
            4'b0101: begin src = b;  addend = im; ld_b = 1'b1; end  // ADD B,im
            4'b0110: begin src = sw; ld_b = 1'b1; end               // IN B
            4'b0111: begin addend = im; ld_b = 1'b1; end            // MOV B,im
            4'b1001: begin src = b;  ld_out = 1'b1; end             // OUT B
            4'b1011: begin addend = im; ld_out = 1'b1; end          // OUT im
            4'b1110: begin                                          // JNC im
                if (!c) begin
                    pc_next = im;
                end
            end
            4'b1111: pc_next = im;                                  // JMP im
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a     <= 4'd0;
            b     <= 4'd0;
            out_q <= 4'd0;
            pc    <= 4'd0;
            c     <= 1'b0;
        end else begin
            pc <= pc_next;
            c  <= sum5[4];
            if (ld_a) begin
                a <= result;
            end
            if (ld_b) begin
                b <= result;
            end
            if (ld_out) begin
                out_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_td4_top.sv
// Testbench for td4_top. Five CPUs share the clock, reset and sw. Each one runs
// a different ROM image: the default counter, an IN/MOV/OUT program, JNC not
// taken, JNC taken, and a mixed program that reads a randomized sw. An
// instruction-level model in the bench pushes the expected LED values of all
// five CPUs into a queue on each rising edge. A monitor pops that queue on
// the falling edge and compares. The bench also checks the directed milestones
// with constants.
module tb_td4_top;

    localparam int N = 5;
    localparam logic [127:0] P0 = 128'h0000_0000_0000_0000_0000_0000_F151_9070;
    localparam logic [127:0] P1 = 128'h0000_0000_0000_0000_0000_0000_F390_4020;
    localparam logic [127:0] P2 = 128'h0000_0000_0000_0000_0000_F5B9_E001_013E;
    localparam logic [127:0] P3 = 128'h0000_0000_0000_0000_0000_00F4_B6BF_E331;
    localparam logic [127:0] P4 = 128'h0000_0000_E0A5_0C15_6290_9053_E640_0720;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] led0, led1, led2, led3, led4;
    logic [3:0] led [N];

    always #5 clock = ~clock;

    td4_top #(.PROGRAM(P0)) u0 (.clock(clock), .reset(reset), .sw(sw), .LED(led0));
    td4_top #(.PROGRAM(P1)) u1 (.clock(clock), .reset(reset), .sw(sw), .LED(led1));
    td4_top #(.PROGRAM(P2)) u2 (.clock(clock), .reset(reset), .sw(sw), .LED(led2));
    td4_top #(.PROGRAM(P3)) u3 (.clock(clock), .reset(reset), .sw(sw), .LED(led3));
    td4_top #(.PROGRAM(P4)) u4 (.clock(clock), .reset(reset), .sw(sw), .LED(led4));

    assign led[0] = led0;
    assign led[1] = led1;
    assign led[2] = led2;
    assign led[3] = led3;
    assign led[4] = led4;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    // Model state of each CPU.
    logic [7:0] rom [N][16];
    logic [3:0] ma  [N];
    logic [3:0] mb  [N];
    logic [3:0] mo  [N];
    logic [3:0] mpc [N];
    logic       mc  [N];

    logic [N-1:0][3:0] expq [$];

    function automatic logic [127:0] prog(input int i);
        case (i)
            0: return P0;
            1: return P1;
            2: return P2;
            3: return P3;
            default: return P4;
        endcase
    endfunction

    function automatic void check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            ma[i] = 4'd0; mb[i] = 4'd0; mo[i] = 4'd0; mpc[i] = 4'd0; mc[i] = 1'b0;
        end
    endfunction

    // The instruction set, described as what each instruction does.
    function automatic void model_step(input logic [3:0] s);
        logic [7:0] ins;
        logic [3:0] op, im, nxt;
        logic [4:0] sum;
        logic       cy;
        for (int i = 0; i < N; i++) begin
            ins = rom[i][mpc[i]];
            op  = ins[7:4];
            im  = ins[3:0];
            nxt = mpc[i] + 4'd1;
            cy  = 1'b0;
            case (op)
                4'h0: begin sum = {1'b0, ma[i]} + {1'b0, im}; ma[i] = sum[3:0]; cy = sum[4]; end
                4'h1: ma[i] = mb[i];
                4'h2: ma[i] = s;
                4'h3: ma[i] = im;
                4'h4: mb[i] = ma[i];
                4'h5: begin sum = {1'b0, mb[i]} + {1'b0, im}; mb[i] = sum[3:0]; cy = sum[4]; end
                4'h6: mb[i] = s;
                4'h7: mb[i] = im;
                4'h9: mo[i] = mb[i];
                4'hB: mo[i] = im;
                4'hE: if (mc[i] == 1'b0) nxt = im;
                4'hF: nxt = im;
                default: ;
            endcase
            mc[i]  = cy;
            mpc[i] = nxt;
        end
    endfunction

    function automatic logic [N-1:0][3:0] model_leds();
        logic [N-1:0][3:0] e;
        for (int i = 0; i < N; i++) e[i] = mo[i];
        return e;
    endfunction

    // Stimulus side of the scoreboard: advance the model on each edge.
    initial begin : stepper
        forever begin
            @(posedge clock);
            if (reset === 1'b1) model_step(sw);
            expq.push_back(model_leds());
        end
    end

    // Checking side of the scoreboard.
    initial begin : monitor
        logic [N-1:0][3:0] e;
        forever begin
            @(negedge clock);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (armed) begin
                    for (int i = 0; i < N; i++) check($sformatf("sb_led%0d", i), led[i], e[i]);
                end
            end
        end
    end

    // Hold reset low for 155 ns, starting p ns after a falling edge.
    task automatic pulse_reset(input int p);
        @(negedge clock);
        #p;
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < expq.size(); j++) expq[j] = '0;
        armed = 1'b1;
        #1;
        for (int i = 0; i < N; i++) check($sformatf("rst_led%0d", i), led[i], 4'd0);
        #154;
        reset = 1'b1;
    endtask

    // Milestones that hold for the first n edges after a release.
    task automatic directed(input int n, input bit all_progs);
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #2;
            if (k >= 2 && (k - 2) % 3 == 0) check("count_led0", led[0], 4'((k - 2) / 3));
            if (all_progs) begin
                check("inout_led1", led[1], (k >= 3) ? 4'd5 : 4'd0);
                check("jnc_nt_led2", led[2], (k >= 5) ? 4'd9 : 4'd0);
                check("jnc_t_led3", led[3], (k >= 3) ? 4'd6 : 4'd0);
            end
        end
    endtask

    initial begin : main
        int phases [6] = '{1, 2, 3, 6, 7, 8};
        bit seen;
        for (int i = 0; i < N; i++)
            for (int n = 0; n < 16; n++) rom[i][n] = prog(i)[8*n +: 8];
        reset = 1'bx;
        sw    = 4'd5;
        model_reset();

        pulse_reset(1);
        directed(60, 1'b1);

        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            #1;
            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) pulse_reset(phases[$urandom_range(0, 5)]);
        end

        // Reset partway through the count.
        pulse_reset(3);
        sw   = 4'd0;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(posedge clock);
            #2;
            if (led0 == 4'd7) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL count_to_7_timeout: got led0=%h expected 7", led0);
        end
        pulse_reset(2);
        directed(25, 1'b0);

        repeat (2) @(negedge clock);
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count: got %0d expected at least 12", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
